// File: rtl/fnn_layer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fnn_layer_sequencer: streams one activation vector onto a shared neuron    |
// | bus and assembles the neuron outputs for the next layer. Optional WAIT     |
// | watchdog enabled by defining FNN_SEQ_TIMEOUT_EN.                           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fnn_layer_sequencer #(
  parameter int numInputs     = 10,
  parameter int numNeurons    = 10,
  parameter int dataWidth     = 16,
  parameter int timeoutCycles = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [numInputs*dataWidth-1:0]   in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [dataWidth-1:0]             nrn_input,
  output logic                             nrn_inputValid,
  input  logic [numNeurons*dataWidth-1:0]  nrn_out,
  input  logic [numNeurons-1:0]            nrn_outvalid,
  output logic [numNeurons*dataWidth-1:0]  out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             busy,
  output logic                             err
);

  localparam int IDX_W = $clog2(numInputs + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(numInputs);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    WAIT   = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  state_t                          state;
  logic [numInputs*dataWidth-1:0]  in_buf;
  logic [IDX_W-1:0]                idx;
  logic [numNeurons-1:0]           done;
  logic [numNeurons-1:0]           done_next;
  logic                            all_done;
  logic                            timeout;

  if (timeoutCycles < 1) begin : g_timeout_range
    $error("timeoutCycles must be at least 1");
  end

  assign done_next = done | nrn_outvalid;
  assign all_done  = &done_next;

`ifdef FNN_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(timeoutCycles + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(timeoutCycles);

  logic [WD_W-1:0] wd_cnt;
  logic [WD_W-1:0] wd_next;

  assign wd_next = (wd_cnt == WD_LIMIT) ? wd_cnt : wd_cnt + 1'b1;
  assign timeout = (wd_next == WD_LIMIT);
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      in_buf         <= '0;
      idx            <= '0;
      done           <= '0;
      in_ready       <= 1'b1;
      nrn_input      <= '0;
      nrn_inputValid <= 1'b0;
      out_data       <= '0;
      out_valid      <= 1'b0;
      busy           <= 1'b0;
`ifdef FNN_SEQ_TIMEOUT_EN
      wd_cnt         <= '0;
      err            <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Element 0 goes out directly; the rest are shifted down one per cycle.
            nrn_input      <= in_data[dataWidth-1:0];
            nrn_inputValid <= 1'b1;
            in_buf         <= in_data >> dataWidth;
            idx            <= IDX_W'(1);
            out_data       <= '0;
            in_ready       <= 1'b0;
            busy           <= 1'b1;
            state          <= STREAM;
          end
        end
        STREAM: begin
          if (idx == IDX_LAST) begin
            nrn_inputValid <= 1'b0;
            state          <= WAIT;
`ifdef FNN_SEQ_TIMEOUT_EN
            wd_cnt         <= '0;
`endif
          end else begin
            nrn_input <= in_buf[dataWidth-1:0];
            in_buf    <= in_buf >> dataWidth;
            idx       <= idx + 1'b1;
          end
        end
        WAIT: begin
          for (int i = 0; i < numNeurons; i++) begin
            if (nrn_outvalid[i]) begin
              out_data[i*dataWidth +: dataWidth] <= nrn_out[i*dataWidth +: dataWidth];
            end
          end
          done <= done_next;
`ifdef FNN_SEQ_TIMEOUT_EN
          wd_cnt <= wd_next;
          if (timeout && !all_done) begin
            err <= 1'b1;
          end
`endif
          // Slices never reported stay zero because out_data is cleared on capture.
          if (all_done || timeout) begin
            out_valid <= 1'b1;
            state     <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            done      <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fnn_layer_sequencer.sv
`default_nettype none
// Bench for fnn_layer_sequencer: stream elements and result vectors are checked
// against expectations queued when the stimulus is driven.
module tb_fnn_layer_sequencer;

  localparam int NI = 4;
  localparam int NN = 3;
  localparam int DW = 16;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NI*DW-1:0]  in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DW-1:0]     nrn_input;
  logic              nrn_inputValid;
  logic [NN*DW-1:0]  nrn_out = '0;
  logic [NN-1:0]     nrn_outvalid = '0;
  logic [NN*DW-1:0]  out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              busy;
  logic              err;

  int total = 0;
  int bad = 0;
  int stream_cnt = 0;
  logic [DW-1:0]    stream_q[$];
  logic [NN*DW-1:0] out_q[$];

  fnn_layer_sequencer #(
    .numInputs(NI), .numNeurons(NN), .dataWidth(DW), .timeoutCycles(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .nrn_input(nrn_input), .nrn_inputValid(nrn_inputValid),
    .nrn_out(nrn_out), .nrn_outvalid(nrn_outvalid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && nrn_inputValid) begin
      stream_cnt++;
      if (stream_q.size() == 0) check("stream_extra", 64'd1, 64'd0);
      else check("stream_elem", nrn_input, stream_q.pop_front());
    end
    if (rst && out_valid && out_ready) begin
      if (out_q.size() == 0) check("out_extra", 64'd1, 64'd0);
      else check("out_data", out_data, out_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [NI*DW-1:0] v);
    check("in_ready_idle", in_ready, 64'd1);
    for (int i = 0; i < NI; i++) stream_q.push_back(v[i*DW +: DW]);
    in_data  = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_stream_end();
    int n;
    n = 0;
    while (nrn_inputValid && n < 20) begin
      tick();
      n++;
    end
    if (nrn_inputValid) check("stream_end_timeout", 64'd0, 64'd1);
  endtask

  task automatic pulse(input logic [NN-1:0] m, input logic [NN*DW-1:0] d);
    nrn_outvalid = m;
    nrn_out      = d;
    tick();
    nrn_outvalid = '0;
    nrn_out      = {NN{16'hDEAD}};
  endtask

  task automatic take(input logic [NN*DW-1:0] exp);
    out_q.push_back(exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 64'd0);
    check("in_ready_back", in_ready, 64'd1);
    check("busy_idle", busy, 64'd0);
  endtask

  initial begin
    int c0;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 64'd1);
    check("rst_out_valid", out_valid, 64'd0);
    check("rst_nrn_valid", nrn_inputValid, 64'd0);
    check("rst_busy", busy, 64'd0);
    check("rst_err", err, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    rst = 1'b1;
    tick();

    // Vector 1: stream 1..4, outputs arrive in two batches, held under backpressure.
    c0 = stream_cnt;
    send({16'h4, 16'h3, 16'h2, 16'h1});
    check("v1_in_ready", in_ready, 64'd0);
    check("v1_busy", busy, 64'd1);
    check("v1_first_valid", nrn_inputValid, 64'd1);
    wait_stream_end();
    check("v1_stream_len", stream_cnt - c0, 64'd4);
    pulse(3'b101, {16'hCCCC, 16'h1234, 16'hAAAA});
    tick();
    tick();
    check("v1_partial_no_out", out_valid, 64'd0);
    pulse(3'b010, {16'h5555, 16'hBBBB, 16'h6666});
    check("v1_out_valid", out_valid, 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("v1_hold_data", out_data, {16'hCCCC, 16'hBBBB, 16'hAAAA});
      check("v1_hold_valid", out_valid, 64'd1);
      tick();
    end
    check("v1_in_ready_out", in_ready, 64'd0);
    take({16'hCCCC, 16'hBBBB, 16'hAAAA});

    // Stray outvalid in IDLE must not mark any neuron done.
    pulse(3'b111, {16'h0909, 16'h0909, 16'h0909});

    // Vector 2: in_valid held high with junk data during STREAM/WAIT.
    send({16'h8, 16'h7, 16'h6, 16'h5});
    in_valid = 1'b1;
    in_data  = {16'hEEEE, 16'hEEEE, 16'hEEEE, 16'hEEEE};
    wait_stream_end();
    check("v2_in_ready_wait", in_ready, 64'd0);
    pulse(3'b101, {16'h0C02, 16'h1111, 16'h0A02});
    tick();
    tick();
    check("v2_stray_ignored", out_valid, 64'd0);
    pulse(3'b010, {16'h2222, 16'h0B02, 16'h3333});
    check("v2_out_valid", out_valid, 64'd1);
    // Vector 3 is presented during OUTPUT and accepted right after the handshake.
    in_data = {16'h0C, 16'h0B, 16'h0A, 16'h09};
    for (int i = 0; i < NI; i++) stream_q.push_back(in_data[i*DW +: DW]);
    take({16'h0C02, 16'h0B02, 16'h0A02});
    tick();
    in_valid = 1'b0;
    check("v3_b2b_start", nrn_inputValid, 64'd1);
    wait_stream_end();
    pulse(3'b111, {16'h0033, 16'h0022, 16'h0011});
    check("v3_all_same_cycle", out_valid, 64'd1);
    take({16'h0033, 16'h0022, 16'h0011});

    // Vector 4: asynchronous reset after two streamed elements.
    c0 = stream_cnt;
    send({16'h44, 16'h43, 16'h42, 16'h41});
    tick();
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_mid_nrn_valid", nrn_inputValid, 64'd0);
    check("rst_mid_in_ready", in_ready, 64'd1);
    check("rst_mid_busy", busy, 64'd0);
    check("rst_mid_elems", stream_cnt - c0, 64'd2);
    stream_q.delete();
    tick();
    rst = 1'b1;
    tick();

    // Vector 5: neuron 1 withholds its output.
    send({16'h54, 16'h53, 16'h52, 16'h51});
    wait_stream_end();
    pulse(3'b101, {16'h00C6, 16'h7777, 16'h00A6});
`ifdef FNN_SEQ_TIMEOUT_EN
    c0 = 0;
    while (!out_valid && c0 < 30) begin
      tick();
      c0++;
    end
    check("wd_out_valid", out_valid, 64'd1);
    check("wd_err", err, 64'd1);
    check("wd_out_data", out_data, {16'h00C6, 16'h0000, 16'h00A6});
    take({16'h00C6, 16'h0000, 16'h00A6});
    check("wd_err_sticky", err, 64'd1);
`else
    repeat (100) tick();
    check("nowd_still_waiting", out_valid, 64'd0);
    check("nowd_busy", busy, 64'd1);
    check("nowd_err", err, 64'd0);
    pulse(3'b010, {16'h8888, 16'h00B6, 16'h9999});
    check("nowd_out_valid", out_valid, 64'd1);
    take({16'h00C6, 16'h00B6, 16'h00A6});
`endif

    tick();
    check("stream_q_empty", stream_q.size(), 64'd0);
    check("out_q_empty", out_q.size(), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
